// File: rtl/orb_descriptor_framer.sv
// ORB BRIEF output framer: masks and caps keypoints, frames them between start/end
// records and buffers the records in a valid/ready FIFO.
module orb_descriptor_framer #(
   parameter int DESC_BITS  = 256,
   parameter int POS_W      = 16,
   parameter int BORDER     = 15,
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_KP     = 1023,
   localparam int REC_W     = DESC_BITS + 2 * POS_W,
   localparam int CNT_W     = $clog2(MAX_KP + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_vs,
   input  logic                 i_hs,
   input  logic                 i_kp,
   input  logic [DESC_BITS-1:0] i_desc,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_start,
   output logic                 o_end,
   output logic [REC_W-1:0]     o_value,
   output logic [CNT_W-1:0]     o_kp_count,
   output logic                 o_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(IMG_W + 1);
   localparam int RW = $clog2(IMG_H + 1);
   localparam int MW = REC_W + 2;

   typedef enum logic {
      IDLE,
      FRAME
   } state_t;

   state_t state, state_nx;

   // Input stage
   logic                 vs_r, vs_p, hs_r, kp_r, armed;
   logic [DESC_BITS-1:0] desc_r;
   logic [CW-1:0]        col_r;
   logic [RW-1:0]        row_r;

   // Frame bookkeeping
   logic [CNT_W-1:0] kp_cnt;
   logic             ovf;

   // FIFO
   logic [MW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic [AW:0]   free;
   logic [MW-1:0] head;

   // Decisions
   logic             vs_rise, vs_fall, kp_ok, in_mask;
   logic             push, pop;
   logic             w_start, w_end;
   logic [REC_W-1:0] w_data;
   logic             kp_inc, ovf_set, clr;
   logic [POS_W-1:0] pos_x, pos_y;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vs_r   <= 1'b0;
         vs_p   <= 1'b0;
         hs_r   <= 1'b0;
         kp_r   <= 1'b0;
         armed  <= 1'b0;
         desc_r <= '0;
         col_r  <= '0;
         row_r  <= '0;
      end else begin
         vs_r   <= i_vs;
         vs_p   <= vs_r;
         hs_r   <= i_hs;
         kp_r   <= i_kp;
         desc_r <= i_desc;
         // a frame already running at reset release must not look like a rise
         armed  <= armed | ~i_vs;
         if (i_hs) begin
            col_r <= hs_r ? col_r + CW'(1) : '0;
         end
         if (i_vs && !vs_r) begin
            row_r <= '0;
         end else if (!i_hs && hs_r) begin
            row_r <= row_r + RW'(1);
         end
      end
   end

   assign vs_rise = vs_r & ~vs_p & armed;
   assign vs_fall = ~vs_r & vs_p;

   assign in_mask = (col_r > CW'(BORDER))
                 && (col_r < CW'(IMG_W - BORDER))
                 && (row_r > RW'(BORDER))
                 && (row_r < RW'(IMG_H - BORDER));

   assign kp_ok = kp_r & hs_r & in_mask;

   assign pos_x = POS_W'(col_r) - POS_W'(BORDER);
   assign pos_y = POS_W'(row_r) - POS_W'(BORDER);

   assign free = (AW + 1)'(FIFO_DEPTH) - count;
   assign pop  = o_valid & i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      push     = 1'b0;
      w_start  = 1'b0;
      w_end    = 1'b0;
      w_data   = '0;
      kp_inc   = 1'b0;
      ovf_set  = 1'b0;
      clr      = 1'b0;
      unique case (state)
         IDLE: begin
            if (vs_rise) begin
               if (free >= (AW + 1)'(2)) begin
                  push     = 1'b1;
                  w_start  = 1'b1;
                  clr      = 1'b1;
                  state_nx = FRAME;
               end else begin
                  ovf_set = 1'b1;
               end
            end
         end
         FRAME: begin
            if (vs_fall) begin
               push     = 1'b1;
               w_end    = 1'b1;
               w_data   = REC_W'({ovf, kp_cnt});
               state_nx = IDLE;
            end else if (kp_ok) begin
               // one slot stays reserved so the end record always fits
               if (kp_cnt < CNT_W'(MAX_KP)
                   && free >= (AW + 1)'(2)) begin
                  push   = 1'b1;
                  w_data = {desc_r, pos_y, pos_x};
                  kp_inc = 1'b1;
               end else begin
                  ovf_set = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         kp_cnt <= '0;
         ovf    <= 1'b0;
      end else begin
         if (clr) begin
            kp_cnt <= '0;
            ovf    <= 1'b0;
         end else begin
            if (kp_inc) begin
               kp_cnt <= kp_cnt + CNT_W'(1);
            end
            if (ovf_set) begin
               ovf <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wptr] <= {w_start, w_end, w_data};
      end
   end

   assign head    = mem[rptr];
   assign o_valid = (count != '0);

   always_comb begin
      o_start = 1'b0;
      o_end   = 1'b0;
      o_value = '0;
      if (o_valid) begin
         {o_start, o_end, o_value} = head;
      end
   end

   assign o_kp_count = kp_cnt;
   assign o_overflow = ovf;

endmodule

// File: tb/tb_orb_descriptor_framer.sv
// Directed bench for orb_descriptor_framer: two instances share one pixel
// stream, one with a keypoint cap of 3, one with an 8-entry FIFO.
module tb_orb_descriptor_framer;

   localparam int W  = 64;
   localparam int H  = 40;

   typedef struct packed {
      logic        s;
      logic        e;
      logic [63:0] v;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vs = 1'b0;
   logic        hs = 1'b0;
   logic        kp = 1'b0;
   logic [31:0] desc = '0;
   logic        ready_a = 1'b1;
   logic        ready_b = 1'b1;

   logic        va, sa, ea, ofa;
   logic [63:0] vala;
   logic [1:0]  kca;
   logic        vb, sb, eb, ofb;
   logic [63:0] valb;
   logic [9:0]  kcb;

   orb_descriptor_framer #(
      .DESC_BITS(32), .POS_W(16), .BORDER(15), .IMG_W(W), .IMG_H(H),
      .FIFO_DEPTH(16), .MAX_KP(3)
   ) dut_a (
      .i_clk(clk), .i_rst(rst), .i_vs(vs), .i_hs(hs), .i_kp(kp),
      .i_desc(desc), .o_valid(va), .i_ready(ready_a), .o_start(sa),
      .o_end(ea), .o_value(vala), .o_kp_count(kca), .o_overflow(ofa)
   );

   orb_descriptor_framer #(
      .DESC_BITS(32), .POS_W(16), .BORDER(15), .IMG_W(W), .IMG_H(H),
      .FIFO_DEPTH(8), .MAX_KP(1023)
   ) dut_b (
      .i_clk(clk), .i_rst(rst), .i_vs(vs), .i_hs(hs), .i_kp(kp),
      .i_desc(desc), .o_valid(vb), .i_ready(ready_b), .o_start(sb),
      .o_end(eb), .o_value(valb), .o_kp_count(kcb), .o_overflow(ofb)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   stab_err = 0;
   rec_t qa[$];
   rec_t qb[$];
   int   kpr[$];
   int   kpc[$];
   logic pv = 1'b0;
   logic pr = 1'b0;
   rec_t prec = '0;

   always @(negedge clk) begin
      if (rst) begin
         pv <= 1'b0;
      end else begin
         if (va && ready_a) qa.push_back({sa, ea, vala});
         if (vb && ready_b) qb.push_back({sb, eb, valb});
         if (pv && !pr && (!vb || {sb, eb, valb} != prec)) stab_err <= stab_err + 1;
         pv   <= vb;
         pr   <= ready_b;
         prec <= {sb, eb, valb};
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic is_kp(input int r, input int c);
      foreach (kpr[i]) if (kpr[i] == r && kpc[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] mkdesc(input int r, input int c);
      return 32'hA500_0000 | (32'(r) << 8) | 32'(c);
   endfunction

   function automatic rec_t mk(input logic s, input logic e, input logic [63:0] v);
      rec_t x;
      x.s = s;
      x.e = e;
      x.v = v;
      return x;
   endfunction

   function automatic rec_t kprec(input int r, input int c);
      return mk(1'b0, 1'b0, {mkdesc(r, c), 16'(r - 15), 16'(c - 15)});
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ab_*: drop vs at that pixel; rs_*: pulse reset at that pixel
   task automatic drive_frame(input int ab_r, input int ab_c,
                              input int rs_r, input int rs_c, input bit lat);
      int  rel;
      bit  done;
      rel  = -1;
      done = 1'b0;
      cyc();
      vs = 1'b1; hs = 1'b0; kp = 1'b0;
      cyc();
      if (lat) begin
         @(negedge clk);
         chk("latency_t1", vb, 0);
      end
      cyc();
      if (lat) begin
         @(negedge clk);
         chk("latency_t2", vb, 1);
      end
      for (int r = 0; r < H && !done; r++) begin
         for (int c = 0; c < W; c++) begin
            cyc();
            hs = 1'b1;
            kp = is_kp(r, c);
            desc = mkdesc(r, c);
            if (rel > 0) begin
               rel--;
               if (rel == 0) rst = 1'b0;
            end
            if (r == rs_r && c == rs_c) begin
               rst = 1'b1;
               ready_b = 1'b1;
               #1;
               chk("rst_valid", vb, 0);
               chk("rst_value", valb, 0);
               chk("rst_kp_count", kcb, 0);
               chk("rst_start_a", sa, 0);
               qa.delete();
               qb.delete();
               rel = 3;
            end
            if (r == ab_r && c == ab_c) begin
               vs = 1'b0;
               done = 1'b1;
               break;
            end
         end
         repeat (4) begin
            cyc();
            hs = 1'b0;
            kp = 1'b0;
         end
      end
      cyc();
      vs = 1'b0; hs = 1'b0; kp = 1'b0;
      repeat (8) cyc();
   endtask

   initial begin
      repeat (3) cyc();
      chk("reset_valid", vb, 0);
      chk("reset_value", valb, 0);
      chk("reset_overflow", ofb, 0);
      chk("reset_kp_count_a", kca, 0);
      rst = 1'b0;
      repeat (2) cyc();

      // single keypoint at col 20, row 18
      kpr = '{18}; kpc = '{20};
      qa.delete(); qb.delete();
      drive_frame(-1, -1, -1, -1, 1'b1);
      chk("t1_size", qb.size(), 3);
      chk("t1_start", qb[0], mk(1'b1, 1'b0, 64'd0));
      chk("t1_xy", qb[1].v[31:0], 32'h0003_0005);
      chk("t1_kp", qb[1], kprec(18, 20));
      chk("t1_end", qb[2], mk(1'b0, 1'b1, 64'd1));
      chk("t1_kp_count", kcb, 1);
      chk("t1_overflow", ofb, 0);

      // keypoints just outside the horizontal mask
      kpr = '{20, 20}; kpc = '{15, 49};
      qa.delete(); qb.delete();
      drive_frame(-1, -1, -1, -1, 1'b0);
      chk("t2_size", qb.size(), 2);
      chk("t2_end", qb[1], mk(1'b0, 1'b1, 64'd0));
      chk("t2_kp_count", kcb, 0);

      // five keypoints against a cap of three
      kpr = '{20, 20, 20, 20, 20}; kpc = '{20, 21, 22, 23, 24};
      qa.delete(); qb.delete();
      drive_frame(-1, -1, -1, -1, 1'b0);
      chk("t3_size", qa.size(), 5);
      chk("t3_kp0", qa[1], kprec(20, 20));
      chk("t3_kp2", qa[3], kprec(20, 22));
      chk("t3_end", qa[4], mk(1'b0, 1'b1, 64'd7));
      chk("t3_kp_count", kca, 3);
      chk("t3_overflow", ofa, 1);

      // back-pressure for the whole frame on the 8-deep FIFO
      kpr.delete(); kpc.delete();
      for (int c = 17; c < 37; c++) begin
         kpr.push_back(20);
         kpc.push_back(c);
      end
      qa.delete(); qb.delete();
      ready_b = 1'b0;
      drive_frame(-1, -1, -1, -1, 1'b0);
      @(negedge clk);
      chk("t4_held_valid", vb, 1);
      chk("t4_held_start", sb, 1);
      chk("t4_kp_count", kcb, 6);
      chk("t4_overflow", ofb, 1);
      chk("t4_no_transfer", qb.size(), 0);
      cyc();
      ready_b = 1'b1;
      repeat (12) cyc();
      chk("t4_size", qb.size(), 8);
      chk("t4_start", qb[0], mk(1'b1, 1'b0, 64'd0));
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t4_kp%0d", i), qb[i + 1], kprec(20, 17 + i));
      end
      chk("t4_end", qb[7], mk(1'b0, 1'b1, 64'd1030));
      chk("t4_stable", stab_err, 0);

      // keypoint on the same cycle as the vs fall
      kpr = '{18}; kpc = '{20};
      qa.delete(); qb.delete();
      drive_frame(18, 20, -1, -1, 1'b0);
      chk("t5_size", qb.size(), 2);
      chk("t5_end", qb[1], mk(1'b0, 1'b1, 64'd0));
      chk("t5_overflow", ofb, 0);

      // reset mid-line with records queued
      kpr = '{20, 20, 20}; kpc = '{20, 21, 22};
      qa.delete(); qb.delete();
      ready_b = 1'b0;
      drive_frame(-1, -1, 25, 10, 1'b0);
      chk("t6_none_b", qb.size(), 0);
      chk("t6_none_a", qa.size(), 0);
      chk("t6_valid", vb, 0);

      // next frame after reset is framed normally
      kpr = '{18}; kpc = '{20};
      qa.delete(); qb.delete();
      drive_frame(-1, -1, -1, -1, 1'b0);
      chk("t7_size", qb.size(), 3);
      chk("t7_kp", qb[1], kprec(18, 20));
      chk("t7_end", qb[2], mk(1'b0, 1'b1, 64'd1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
